ram_bist_initiator: RTL
=======================

Name: ram_bist_initiator

Overview:
- Built-in self-test initiator that drives the word-wide port of the testbench dual-port RAM and checks its read data.
- Runs a three-phase march over every word: write pattern ascending; read-pattern/write-inverse ascending; read-inverse descending.
- Reports pass/fail, error count and the first failing address.
- Sits in the core testbench on RAM port b, muxed against the core's data port; used for RAM sanity checks before program load.

Parameters:
- ADDR_WIDTH, 8, byte address width of the RAM port. Word count N = 2**ADDR_WIDTH/4.
- PATTERN, 32'hA5A5_5A5A, background pattern. Its bitwise inverse is the second background.

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  start pulse; sampled only in IDLE or DONE
- busy_o  output  1  high while the march is running
- done_o  output  1  high from march completion until the next start
- pass_o  output  1  valid while done_o is high; 1 iff err_cnt_o == 0
- err_cnt_o  output  8  mismatch count, saturates at 255
- fail_addr_o  output  ADDR_WIDTH  byte address of the first mismatch; 0 if none
- en_o  output  1  RAM access enable
- addr_o  output  ADDR_WIDTH  RAM byte address; bits [1:0] always 0
- wdata_o  output  32  RAM write data
- we_o  output  1  RAM write enable
- be_o  output  4  byte enables; constant 4'hF
- rdata_i  input  32  RAM read data, valid the cycle after a read (en_o=1, we_o=0)

Behaviour:
- Reset (async on rst_ni low): state IDLE. busy_o, done_o, pass_o, en_o, we_o = 0. err_cnt_o, fail_addr_o, addr_o, wdata_o = 0. be_o = 4'hF. Compare pipeline cleared.
- Reset mid-march aborts immediately with no further RAM access. Outputs take reset values.
- The RAM port has one-cycle read latency:
  - Every read issue sets chk_q=1 and stores the expected value in exp_q.
  - On the next cycle, if chk_q=1, compare rdata_i with exp_q.
  - On mismatch: err_cnt_o increments, saturating at 255. If this is the first mismatch, the read address (held in a one-stage address pipe) is captured into fail_addr_o.
- States and transitions:
  - IDLE: en_o=0. start_i=1 -> W0 with addr=0. Clear err_cnt_o, fail_addr_o, done_o.
  - W0: en=1, we=1, wdata=PATTERN. addr += 4 each cycle. On addr == 2**ADDR_WIDTH-4 -> R0 with addr=0.
  - R0: en=1, we=0 (read, expect PATTERN) -> W1 at the same addr.
  - W1: en=1, we=1, wdata=~PATTERN; the compare of the R0 read occurs this cycle. On last addr -> R1 with addr held at last; otherwise addr += 4 -> R0.
  - R1: en=1, we=0 (read, expect ~PATTERN). addr -= 4 each cycle. On addr == 0 -> CHK.
  - CHK: en=0; final compare -> DONE.
  - DONE: busy_o=0, done_o=1, pass_o=(err_cnt_o==0). Hold until start_i=1, which re-enters W0 exactly as from IDLE.
- busy_o is high in W0, R0, W1, R1 and CHK. Busy duration is exactly 4N+1 cycles (257 for ADDR_WIDTH=8).
- start_i is ignored while busy_o=1.
- No address ever leaves [0, 2**ADDR_WIDTH-4]. Address arithmetic never wraps.
- All outputs are registered; no combinational path from rdata_i to any output.

Optional Feature:
- Macro: RAM_BIST_INJECT_EN.
- Defined:
  - Adds input port inject_i (1 bit).
  - If inject_i=1 in any cycle where we_o=1, bit 0 of that cycle's wdata_o is inverted. All else is unchanged.
  - Used to self-test the checker.
- Undefined: no inject_i port; wdata_o is always the exact background.

Test Plan:
- Good RAM, ADDR_WIDTH=8, start_i pulse -> busy_o high 257 cycles; done_o=1, pass_o=1, err_cnt_o=0, fail_addr_o=0.
- Address sweep monitor -> 64 writes to 0x00..0xFC ascending, then 64 R/W pairs ascending, then 64 reads 0xFC..0x00 descending; addr_o[1:0] always 0; be_o always 4'hF.
- RAM model with bit 5 stuck-at-1 at word 0x40 -> R0 read of 0x40 mismatches, R1 read matches; err_cnt_o=1, fail_addr_o=0x40, pass_o=0.
- RAM model returning 0 for all reads -> err_cnt_o=128, fail_addr_o=0x00, pass_o=0. Repeat with ADDR_WIDTH=12 -> err_cnt_o saturates at 255.
- rst_ni low at cycle 100 of the march -> en_o/busy_o fall asynchronously. After release, start_i gives a full clean pass with err_cnt_o reset to 0.
- RAM_BIST_INJECT_EN defined, inject_i=1 during the W0 write to 0x08 -> err_cnt_o=1, fail_addr_o=0x08. Also start_i pulses while busy -> no restart, busy length unchanged.

Source files
------------

// File: rtl/ram_bist_initiator.sv
// March-style BIST initiator for the word-wide RAM port: W0 up, R0/W1 up, R1 down, then compare.
// Optional RAM_BIST_INJECT_EN adds inject_i, which flips wdata bit 0 on write cycles to exercise the checker.
module ram_bist_initiator #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] PATTERN    = 32'hA5A5_5A5A
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [7:0]            err_cnt_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic                  en_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [31:0]           wdata_o,
  output logic                  we_o,
  output logic [3:0]            be_o,
  input  logic [31:0]           rdata_i
`ifdef RAM_BIST_INJECT_EN
  ,
  input  logic                  inject_i
`endif
);

  typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, CHK, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_d, fail_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    en_d, we_d, busy_d, done_d, pass_d, mis;
  logic [7:0]              err_d;

  logic                    vld_p1;
  logic [31:0]             exp_p1;
  logic [ADDR_WIDTH-1:0]   raddr_p1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_o;
    en_d    = 1'b0;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    err_d   = err_cnt_o;
    fail_d  = fail_addr_o;
    mis     = vld_p1 && (rdata_i != exp_p1);
    if (mis) begin
      if (err_cnt_o == 8'd0) fail_d = raddr_p1;
      err_d = sat_inc(err_cnt_o);
    end
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = W0;
          addr_d  = '0;
          en_d    = 1'b1;
          we_d    = 1'b1;
          wdata_d = PATTERN;
          err_d   = '0;
          fail_d  = '0;
        end
      end
      W0: begin
        en_d = 1'b1;
        if (addr_o == LAST) begin
          state_d = R0;
          addr_d  = '0;
        end else begin
          addr_d  = addr_o + STEP;
          we_d    = 1'b1;
          wdata_d = PATTERN;
        end
      end
      R0: begin
        state_d = W1;
        en_d    = 1'b1;
        we_d    = 1'b1;
        wdata_d = ~PATTERN;
      end
      W1: begin
        en_d = 1'b1;
        if (addr_o == LAST) begin
          state_d = R1;
        end else begin
          state_d = R0;
          addr_d  = addr_o + STEP;
        end
      end
      R1: begin
        if (addr_o == '0) begin
          state_d = CHK;
        end else begin
          en_d   = 1'b1;
          addr_d = addr_o - STEP;
        end
      end
      CHK:     state_d = DONE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d inside {W0, R0, W1, R1, CHK});
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == 8'd0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_o      <= '0;
      en_o        <= 1'b0;
      we_o        <= 1'b0;
      wdata_q     <= '0;
      err_cnt_o   <= '0;
      fail_addr_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_o      <= addr_d;
      en_o        <= en_d;
      we_o        <= we_d;
      wdata_q     <= wdata_d;
      err_cnt_o   <= err_d;
      fail_addr_o <= fail_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      pass_o      <= pass_d;
    end
  end

  // Stage p1: read data returns one cycle after issue, compared against the background in exp_p1
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1   <= 1'b0;
      exp_p1   <= '0;
      raddr_p1 <= '0;
    end else begin
      vld_p1   <= en_o && !we_o;
      exp_p1   <= (state_q == R0) ? PATTERN : ~PATTERN;
      raddr_p1 <= addr_o;
    end
  end

`ifdef RAM_BIST_INJECT_EN
  assign wdata_o = wdata_q ^ {31'd0, inject_i & we_o};
`else
  assign wdata_o = wdata_q;
`endif
  assign be_o = 4'hF;

endmodule
